// File: rtl/approx_cmp_pkg.sv
// Shared definitions for the approximate serial comparator family: nibble width,
// controller state encoding and parameter helpers.
package approx_cmp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    function automatic int num_nibbles(input int width);
        return width / NIB_W;
    endfunction

    // Legal iff the operand splits into whole nibbles and at least one nibble is examined.
    function automatic bit params_ok(input int width, input int skip);
        return (width >= NIB_W) && ((width % NIB_W) == 0) &&
               (skip >= 0) && (skip < num_nibbles(width));
    endfunction

endpackage

// File: rtl/nibble_cmp_exact.sv
// Exact combinational 4-bit unsigned comparator slice; equality is implied by
// neither gt nor lt being set.
module nibble_cmp_exact
    import approx_cmp_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic             gt,
    output logic             lt
);

    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/approx_serial_cmp_ctrl.sv
// Sequencer that walks two captured operands MSB-nibble first through a single exact
// 4-bit slice, stopping at the first difference or at the lowest examined nibble.
module approx_serial_cmp_ctrl
    import approx_cmp_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SKIP_NIBBLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          eq,
    output logic                          gt,
    output logic                          lt,
    output logic [$clog2(WIDTH/NIB_W):0]  nib_cnt
);

    localparam int N     = num_nibbles(WIDTH);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N) + 1;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SKIP_NIBBLES);

    if (!params_ok(WIDTH, SKIP_NIBBLES)) begin : g_param_check
        $error("approx_serial_cmp_ctrl: WIDTH must be a multiple of 4 and SKIP_NIBBLES < WIDTH/4");
    end

    state_t                   r_state;
    state_t                   w_next_state;
    logic [WIDTH-1:0]         r_op_a;
    logic [WIDTH-1:0]         r_op_b;
    logic [IDX_W-1:0]         r_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_eq;
    logic                     r_gt;
    logic                     r_lt;
    logic [CNT_W-1:0]         r_nib_cnt;

    logic [N-1:0][NIB_W-1:0]  w_a_nibs;
    logic [N-1:0][NIB_W-1:0]  w_b_nibs;
    logic [NIB_W-1:0]         w_nib_a;
    logic [NIB_W-1:0]         w_nib_b;
    logic                     w_gt;
    logic                     w_lt;
    logic                     w_accept;
    logic                     w_decide;
    logic                     w_step;
    logic                     w_release;

    // One shared slice, fed by the nibble currently selected by idx.
    assign w_a_nibs = r_op_a;
    assign w_b_nibs = r_op_b;
    assign w_nib_a  = w_a_nibs[r_idx];
    assign w_nib_b  = w_b_nibs[r_idx];

    nibble_cmp_exact u_slice (
        .x  (w_nib_a),
        .y  (w_nib_b),
        .gt (w_gt),
        .lt (w_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_decide     = 1'b0;
        w_step       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_gt || w_lt || (r_idx == LAST_IDX)) begin
                    w_decide     = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, scan counters and the held result; results are zero except in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_nib_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= a;
                r_op_b <= b;
                r_idx  <= FIRST_IDX;
                r_cnt  <= '0;
            end
            if (r_state == SCAN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_step) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_decide) begin
                r_eq      <= ~w_gt & ~w_lt;
                r_gt      <= w_gt;
                r_lt      <= w_lt;
                r_nib_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_eq      <= 1'b0;
                r_gt      <= 1'b0;
                r_lt      <= 1'b0;
                r_nib_cnt <= '0;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign nib_cnt   = r_nib_cnt;

endmodule

// File: tb/tb_approx_serial_cmp_ctrl.sv
// Bench for approx_serial_cmp_ctrl: three instances (SKIP_NIBBLES = 0, 1, 2) checked every
// cycle against a transaction-level model, plus directed literal cases and random traffic.
module tb_approx_serial_cmp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid  [3];
    logic        inReady  [3];
    logic [15:0] opA      [3];
    logic [15:0] opB      [3];
    logic        outValid [3];
    logic        outReady [3];
    logic        eqO      [3];
    logic        gtO      [3];
    logic        ltO      [3];
    logic [2:0]  nibCnt   [3];

    int checks   = 0;
    int failures = 0;
    bit checkEn  = 1'b0;

    // Model state per instance: busy from accept until release, age = edges since accept.
    bit          mBusy [3];
    int          mAge  [3];
    logic [5:0]  mExp  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        approx_serial_cmp_ctrl #(.WIDTH(16), .SKIP_NIBBLES(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (inValid[g]),
            .in_ready  (inReady[g]),
            .a         (opA[g]),
            .b         (opB[g]),
            .out_valid (outValid[g]),
            .out_ready (outReady[g]),
            .eq        (eqO[g]),
            .gt        (gtO[g]),
            .lt        (ltO[g]),
            .nib_cnt   (nibCnt[g])
        );
    end

    // Reference result {eq, gt, lt, nib_cnt}: compare the unskipped parts as plain integers;
    // the examined count is set by the most significant differing nibble.
    function automatic logic [5:0] refCmp(input logic [15:0] av, input logic [15:0] bv, input int skip);
        logic [15:0] am;
        logic [15:0] bm;
        int          n;
        int          cnt;
        int          hiBit;
        am = av >> (4 * skip);
        bm = bv >> (4 * skip);
        n  = 4 - skip;
        if (am == bm) begin
            cnt = n;
        end else begin
            hiBit = $clog2(int'(am ^ bm) + 1) - 1;
            cnt   = n - (hiBit / 4);
        end
        return {(am == bm), (am > bm), (am < bm), 3'(cnt)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                mBusy[k] <= 1'b0;
                mAge[k]  <= 0;
                mExp[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!mBusy[k]) begin
                    if (inValid[k]) begin
                        mBusy[k] <= 1'b1;
                        mAge[k]  <= 0;
                        mExp[k]  <= refCmp(opA[k], opB[k], k);
                    end
                end else if (mAge[k] >= int'(mExp[k][2:0])) begin
                    if (outReady[k]) mBusy[k] <= 1'b0;
                end else begin
                    mAge[k] <= mAge[k] + 1;
                end
            end
        end
    end

    // Every cycle: handshake outputs and result fields of each instance against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 3; k++) begin
                bit vld;
                vld = mBusy[k] && (mAge[k] >= int'(mExp[k][2:0]));
                checkOutput($sformatf("cycle_dut%0d", k),
                            {inReady[k], outValid[k], eqO[k], gtO[k], ltO[k], nibCnt[k]},
                            {!mBusy[k], vld, (vld ? mExp[k] : 6'd0)});
            end
        end
    end

    // Called at posedge+2; returns at accept edge + 2 with operands scrambled.
    task automatic issueOperands(input int k, input logic [15:0] av, input logic [15:0] bv);
        bit ok;
        ok         = 1'b0;
        opA[k]     = av;
        opB[k]     = bv;
        inValid[k] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (inReady[k]) ok = 1'b1;
        end
        if (!ok) checkOutput($sformatf("accept_timeout_dut%0d", k), 32'd0, 32'd1);
        @(posedge clk);
        #2;
        inValid[k] = 1'b0;
        opA[k]     = 16'($urandom);
        opB[k]     = 16'($urandom);
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [5:0] expRes, input int hold, input string name);
        int lat;
        bit seen;
        issueOperands(k, av, bv);
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (outValid[k]) seen = 1'b1;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(expRes[2:0]));
        checkOutput({name, "_result"}, {eqO[k], gtO[k], ltO[k], nibCnt[k]}, expRes);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #2;
            inValid[k] = (h % 2 == 0);
            opA[k]     = 16'($urandom);
            opB[k]     = 16'($urandom);
            @(negedge clk);
            checkOutput({name, "_hold"},
                        {inReady[k], outValid[k], eqO[k], gtO[k], ltO[k], nibCnt[k]},
                        {2'b01, expRes});
        end
        @(posedge clk);
        #2;
        inValid[k]  = 1'b0;
        outReady[k] = 1'b1;
        @(posedge clk);
        #2;
        outReady[k] = 1'b0;
        @(negedge clk);
        checkOutput({name, "_release"},
                    {inReady[k], outValid[k], eqO[k], gtO[k], ltO[k], nibCnt[k]}, 8'h80);
        @(posedge clk);
        #2;
    endtask

    // Operand pairs biased toward shared leading nibbles so all scan depths occur.
    task automatic runRandom(input int k, input int count);
        logic [15:0] av;
        logic [15:0] bv;
        bit          done;
        for (int t = 0; t < count; t++) begin
            av = 16'($urandom);
            bv = av;
            if ($urandom_range(0, 9) != 0) begin
                for (int n = 0; n < 4; n++) begin
                    if ($urandom_range(0, 2) == 0) bv[4*n +: 4] = 4'($urandom);
                end
            end
            issueOperands(k, av, bv);
            done = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                outReady[k] = 1'($urandom_range(0, 1));
                @(posedge clk);
                #2;
                if (!mBusy[k]) done = 1'b1;
            end
            if (!done) checkOutput($sformatf("release_timeout_dut%0d", k), 32'd0, 32'd1);
            outReady[k] = 1'b0;
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    initial begin
        #950000;
        $display("[TB] FAIL watchdog simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inValid[k]  = 1'b0;
            outReady[k] = 1'b0;
            opA[k]      = '0;
            opB[k]      = '0;
        end
        repeat (2) @(posedge clk);
        checkEn = 1'b1;
        #2;
        rst = 1'b0;

        checkOutput("ref_eq_full",  32'(refCmp(16'h1234, 16'h1234, 0)), 32'h24);
        checkOutput("ref_gt_top",   32'(refCmp(16'h8000, 16'h7FFF, 0)), 32'h11);
        checkOutput("ref_lt_nib2",  32'(refCmp(16'h12F0, 16'h1300, 0)), 32'h0A);
        checkOutput("ref_eq_skip1", 32'(refCmp(16'h12A5, 16'h12A3, 1)), 32'h23);

        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_state_dut%0d", k),
                        {inReady[k], outValid[k], eqO[k], gtO[k], ltO[k], nibCnt[k]}, 8'h80);
        end
        @(posedge clk);
        #2;

        applyStimulus(0, 16'h1234, 16'h1234, 6'b100_100, 0, "s0_equal");
        applyStimulus(0, 16'h8000, 16'h7FFF, 6'b010_001, 0, "s0_gt_top");
        applyStimulus(0, 16'h12F0, 16'h1300, 6'b001_010, 0, "s0_lt_nib2");
        applyStimulus(1, 16'h12A5, 16'h12A3, 6'b100_011, 0, "s1_approx_eq");
        applyStimulus(1, 16'h1250, 16'h1240, 6'b010_011, 0, "s1_gt_last");
        applyStimulus(2, 16'h1200, 16'h12FF, 6'b100_010, 0, "s2_approx_eq");
        applyStimulus(2, 16'h3400, 16'h3300, 6'b010_010, 0, "s2_gt_last");
        applyStimulus(0, 16'h9000, 16'h1000, 6'b010_001, 5, "s0_backpressure");

        issueOperands(0, 16'h1111, 16'h1112);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_async", {inReady[0], outValid[0], eqO[0], gtO[0], ltO[0], nibCnt[0]}, 8'h80);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("abort_no_valid", {inReady[0], outValid[0]}, 2'b10);
        end
        @(posedge clk);
        #2;
        applyStimulus(0, 16'h0005, 16'h0009, 6'b001_100, 0, "post_reset_lt");

        fork
            runRandom(0, 5000);
            runRandom(2, 5000);
        join

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
